// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// Sizes the byte-wide instruction memory and names the loader FSM states.
package imem_loader_pkg;

    localparam int MEM_DEPTH        = 4096;
    localparam int MEM_WIDTH        = 8;
    localparam int INSTR_WIDTH      = 32;
    localparam int BPI              = INSTR_WIDTH / MEM_WIDTH;
    localparam int MEM_ADDR_WIDTH   = $clog2(MEM_DEPTH);
    localparam int BYTE_IDX_WIDTH   = $clog2(BPI);
    localparam int WORD_COUNT_WIDTH = $clog2(MEM_DEPTH / BPI) + 1;
    localparam int SEL_WIDTH        = $clog2(INSTR_WIDTH);

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_WRITE,
        LD_DONE,
        LD_ERROR
    } imem_ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Loads 32-bit instruction words into byte-wide instruction memory, big-endian.
// Optional running checksum of accepted words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [MEM_ADDR_WIDTH-1:0]   base_addr,
    input  logic                        in_valid,
    input  logic [INSTR_WIDTH-1:0]      in_word,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic                        mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [MEM_WIDTH-1:0]        mem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [WORD_COUNT_WIDTH-1:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [INSTR_WIDTH-1:0]      checksum
`endif
);

    // One extra bit so the pointer can reach MEM_DEPTH without wrapping to 0.
    localparam logic [MEM_ADDR_WIDTH:0]   LAST_WORD_BASE = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH - BPI);
    localparam logic [BYTE_IDX_WIDTH-1:0] LAST_BYTE      = BYTE_IDX_WIDTH'(BPI - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ALIGN_MASK     = ~MEM_ADDR_WIDTH'(BPI - 1);

    imem_ld_state_e              state;
    imem_ld_state_e              nextState;
    logic [MEM_ADDR_WIDTH:0]     wrPtr;
    logic [MEM_ADDR_WIDTH-1:0]   curBase;
    logic [BYTE_IDX_WIDTH-1:0]   byteIdx;
    logic [INSTR_WIDTH-1:0]      wordLatch;
    logic                        lastLatch;
    logic [SEL_WIDTH-1:0]        byteMsb;
    logic                        accept;
    logic                        wordFits;
    logic                        lastByte;

    assign accept   = in_valid & in_ready;
    assign wordFits = (wrPtr <= LAST_WORD_BASE);
    assign lastByte = (byteIdx == LAST_BYTE);
    assign byteMsb  = SEL_WIDTH'(INSTR_WIDTH - 1 - MEM_WIDTH * int'(byteIdx));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= LD_IDLE;
        else        state <= nextState;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        nextState = state;
        if (start) begin
            nextState = LD_LOAD;
        end else begin
            case (state)
                LD_LOAD: begin
                    if (accept) nextState = wordFits ? LD_WRITE : LD_ERROR;
                end
                LD_WRITE: begin
                    if (lastByte) begin
                        if (accept)         nextState = wordFits ? LD_WRITE : LD_ERROR;
                        else if (lastLatch) nextState = LD_DONE;
                        else                nextState = LD_LOAD;
                    end
                end
                default: nextState = state;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        overflow = 1'b0;
        case (state)
            LD_LOAD: begin
                in_ready = !start;
                busy     = 1'b1;
            end
            LD_WRITE: begin
                // Overlap the next accept with the final byte to sustain one word per BPI cycles.
                in_ready = !start && lastByte && !lastLatch;
                busy     = 1'b1;
            end
            LD_DONE:  done     = 1'b1;
            LD_ERROR: overflow = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            byteIdx    <= '0;
            wrPtr      <= '0;
            curBase    <= '0;
            wordLatch  <= '0;
            lastLatch  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                // Abandon any in-flight word; bytes already written are left in memory.
                wrPtr      <= {1'b0, base_addr & ALIGN_MASK};
                byteIdx    <= '0;
                word_count <= '0;
            end else begin
                if (state == LD_WRITE) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= curBase + MEM_ADDR_WIDTH'(byteIdx);
                    mem_wdata <= wordLatch[byteMsb -: MEM_WIDTH];
                    byteIdx   <= byteIdx + BYTE_IDX_WIDTH'(1);
                    if (lastByte) word_count <= word_count + WORD_COUNT_WIDTH'(1);
                end
                if (accept && wordFits) begin
                    wordLatch <= in_word;
                    lastLatch <= in_last;
                    curBase   <= wrPtr[MEM_ADDR_WIDTH-1:0];
                    wrPtr     <= wrPtr + (MEM_ADDR_WIDTH + 1)'(BPI);
                    byteIdx   <= '0;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n || start)          checksum <= '0;
        else if (accept && wordFits)  checksum <= checksum + in_word;
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected byte writes plus scenario tasks.
// Build with IMEM_LOADER_CHECKSUM_EN defined to also exercise the checksum output.
module tb_imem_loader;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [10:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    wr_t         expQ[$];
    wr_t         wrLog[$];
    int          mdlPtr = 0;
    int          mdlWords = 0;
    logic [31:0] mdlSum = '0;
    int          weRun = 0;
    int          maxWeRun = 0;
    logic [31:0] wordBuf[16];

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: each accepted word becomes four big-endian byte writes at the next free slot.
    always @(posedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            mdlPtr = 0;
            mdlWords = 0;
            mdlSum = '0;
        end else if (start) begin
            expQ.delete();
            mdlPtr = int'(base_addr) / 4 * 4;
            mdlWords = 0;
            mdlSum = '0;
        end else if (in_valid && in_ready) begin
            if (mdlPtr + 4 <= 4096) begin
                for (int k = 0; k < 4; k++)
                    expQ.push_back('{addr: 12'(mdlPtr + k), data: 8'(in_word >> (24 - 8 * k))});
                mdlPtr = mdlPtr + 4;
                mdlWords++;
                mdlSum = mdlSum + in_word;
            end
        end
    end

    // Write monitor: every strobed byte must be the next one the model expects.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            wrLog.push_back('{addr: mem_addr, data: mem_wdata});
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = expQ.pop_front();
                if (e.addr !== mem_addr || e.data !== mem_wdata) begin
                    errors++;
                    $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
        weRun = (mem_we === 1'b1) ? weRun + 1 : 0;
        if (weRun > maxWeRun) maxWeRun = weRun;
    end

    task automatic do_start(input logic [11:0] b);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit lastFinal, input bit gaps);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < n && cyc < 400) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_word  = wordBuf[idx];
            in_last  = lastFinal && (idx == n - 1);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL send_timeout: got %0d words accepted, expected %0d", idx, n);
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy !== 1'b0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || expQ.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: got busy=%b pending_bytes=%0d, expected busy=0 pending=0", busy, expQ.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        in_valid = 1'b0;
        in_word = '0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, busy, done, overflow} !== 5'b0 || mem_addr !== 12'h0 ||
            mem_wdata !== 8'h0 || word_count !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b we=%b busy=%b done=%b ovf=%b addr=%h data=%h cnt=%0d, expected all 0",
                     in_ready, mem_we, busy, done, overflow, mem_addr, mem_wdata, word_count);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            errors++;
            $display("FAIL reset_checksum: got %h, expected 00000000", checksum);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [11:0] ea[8] = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007};
        logic [7:0]  ed[8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
        wrLog.delete();
        do_start(12'h000);
        wordBuf[0] = 32'h8C010004;
        wordBuf[1] = 32'h00221820;
        send_words(2, 1'b1, 1'b0);
        wait_idle();
        checks++;
        if (wrLog.size() != 8) begin
            errors++;
            $display("FAIL basic_write_count: got %0d, expected 8", wrLog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wrLog[i].addr !== ea[i] || wrLog[i].data !== ed[i]) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h@%h, expected %h@%h", i, wrLog[i].data, wrLog[i].addr, ed[i], ea[i]);
                end
            end
        end
        in_valid = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || word_count !== 11'd2 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b cnt=%0d rdy=%b busy=%b, expected done=1 cnt=2 rdy=0 busy=0",
                     done, word_count, in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int accCyc[$];
        int idx = 0;
        int c = 0;
        for (int i = 0; i < 3; i++) wordBuf[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        base_addr = 12'h100;
        in_valid = 1'b1;
        in_word = wordBuf[0];
        in_last = 1'b0;
        maxWeRun = 0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_start: got %b, expected 0", in_ready);
        end
        @(negedge clk);
        start = 1'b0;
        while (idx < 3 && c < 40) begin
            in_word = wordBuf[idx];
            in_last = (idx == 2);
            #1;
            if (in_ready) begin
                accCyc.push_back(c);
                idx++;
            end
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        wait_idle();
        checks++;
        if (accCyc.size() != 3 || accCyc[0] != 0 || accCyc[1] != 4 || accCyc[2] != 8) begin
            errors++;
            $display("FAIL b2b_accept_cycles: got %p, expected '{0, 4, 8}", accCyc);
        end
        checks++;
        if (maxWeRun != 12) begin
            errors++;
            $display("FAIL b2b_we_run: got %0d consecutive writes, expected 12", maxWeRun);
        end
        checks++;
        if (done !== 1'b1 || word_count !== 11'd3) begin
            errors++;
            $display("FAIL b2b_done: got done=%b cnt=%0d, expected done=1 cnt=3", done, word_count);
        end
    endtask

    task automatic test_overflow();
        wordBuf[0] = $urandom;
        wordBuf[1] = $urandom;
        do_start(12'hFFC);
        send_words(2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 ||
            word_count !== 11'd1 || expQ.size() != 0) begin
            errors++;
            $display("FAIL overflow_state: got ovf=%b busy=%b done=%b rdy=%b cnt=%0d pending=%0d, expected ovf=1 busy=0 done=0 rdy=0 cnt=1 pending=0",
                     overflow, busy, done, in_ready, word_count, expQ.size());
        end
        in_valid = 1'b0;
        do_start(12'h000);
        #1;
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b busy=%b rdy=%b, expected ovf=0 busy=1 rdy=1", overflow, busy, in_ready);
        end
    endtask

    task automatic test_restart();
        wordBuf[0] = $urandom;
        wordBuf[1] = $urandom;
        do_start(12'h010);
        send_words(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (word_count !== 11'd1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre: got cnt=%0d we=%b, expected cnt=1 we=1", word_count, mem_we);
        end
        start = 1'b1;
        base_addr = 12'h040;
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || word_count !== 11'd0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_abort: got we=%b cnt=%0d done=%b busy=%b, expected we=0 cnt=0 done=0 busy=1",
                     mem_we, word_count, done, busy);
        end
        wrLog.delete();
        wordBuf[0] = $urandom;
        send_words(1, 1'b1, 1'b0);
        wait_idle();
        checks++;
        if (wrLog.size() != 4 || wrLog[0].addr !== 12'h040 || done !== 1'b1 || word_count !== 11'd1) begin
            errors++;
            $display("FAIL restart_reload: got writes=%0d done=%b cnt=%0d, expected 4 writes from 040 done=1 cnt=1",
                     wrLog.size(), done, word_count);
        end
    endtask

    task automatic test_unaligned_base();
        wrLog.delete();
        wordBuf[0] = $urandom;
        do_start(12'h013);
        send_words(1, 1'b1, 1'b0);
        wait_idle();
        checks++;
        if (wrLog.size() != 4 || wrLog[0].addr !== 12'h010) begin
            errors++;
            $display("FAIL unaligned_base: got writes=%0d, expected 4 starting at 010", wrLog.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 6);
            logic [11:0] b = 12'($urandom_range(0, 4096 - 4 * n));
            for (int i = 0; i < n; i++) wordBuf[i] = $urandom;
            do_start(b);
            send_words(n, 1'b1, 1'b1);
            wait_idle();
            checks++;
            if (done !== 1'b1 || int'(word_count) != n || overflow !== 1'b0) begin
                errors++;
                $display("FAIL random_round%0d: got done=%b cnt=%0d ovf=%b, expected done=1 cnt=%0d ovf=0",
                         r, done, word_count, overflow, n);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            checks++;
            if (checksum !== mdlSum) begin
                errors++;
                $display("FAIL random_checksum%0d: got %h, expected %h", r, checksum, mdlSum);
            end
`endif
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        wordBuf[0] = 32'hFFFFFFFF;
        wordBuf[1] = 32'h00000002;
        do_start(12'h200);
        send_words(2, 1'b1, 1'b0);
        wait_idle();
        checks++;
        if (checksum !== 32'h00000001) begin
            errors++;
            $display("FAIL checksum_sum: got %h, expected 00000001", checksum);
        end
        do_start(12'h300);
        checks++;
        if (checksum !== 32'h0) begin
            errors++;
            $display("FAIL checksum_clear: got %h, expected 00000000", checksum);
        end
    endtask
`endif

    task automatic test_reset_wins();
        wordBuf[0] = $urandom;
        do_start(12'h080);
        send_words(1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || word_count !== 11'd0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: got busy=%b rdy=%b cnt=%0d we=%b, expected all 0", busy, in_ready, word_count, mem_we);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b ovf=%b, expected idle with all 0", busy, done, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_restart();
        test_unaligned_base();
        test_random();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
